// File: rtl/axi_lite_rr_arbiter.sv
// rtl/axi_lite_rr_arbiter.sv - round-robin arbiter sharing one AXI-lite master command port
//
// Ports:
//   aclk, areset               clock, synchronous active-high reset
//   req/req_we/req_addr/req_wdata  per-requester command (addr/data packed, requester i at [i*W +: W])
//   ack, rsp_rdata, rsp_resp   one-hot completion pulse plus captured response
//   busy, grant_idx            arbitration status
//   wr_go/rd_go/waddr/raddr/w_data  command to the AXI-lite master
//   bvalid/bready/bresp, rvalid/rready/rdata/rresp  snooped B and R handshakes
module axi_lite_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_wdata,
    output logic [NREQ-1:0]          ack,
    output logic [DW-1:0]            rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_idx,
    output logic                     wr_go,
    output logic                     rd_go,
    output logic [AW-1:0]            waddr,
    output logic [AW-1:0]            raddr,
    output logic [DW-1:0]            w_data,
    input  logic                     bvalid,
    input  logic                     bready,
    input  logic [1:0]               bresp,
    input  logic                     rvalid,
    input  logic                     rready,
    input  logic [DW-1:0]            rdata,
    input  logic [1:0]               rresp
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    logic [IW-1:0]  r_ptr;
    logic           r_we;

    logic           w_pick_valid;
    logic [IW-1:0]  w_pick_idx;
    logic [AW-1:0]  w_pick_addr;
    logic [DW-1:0]  w_pick_wdata;
    logic           w_b_hs;
    logic           w_r_hs;

    // Round-robin search starting at r_ptr. Walking from the lowest priority
    // position back to r_ptr lets the last match win, so the requester
    // closest to the pointer (wrapping at NREQ) is selected.
    always_comb begin
        int j;
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(r_ptr) + k) % NREQ;
            if (req[j]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = IW'(j);
            end
        end
    end

    assign w_pick_addr  = req_addr[int'(w_pick_idx)*AW +: AW];
    assign w_pick_wdata = req_wdata[int'(w_pick_idx)*DW +: DW];
    assign w_b_hs       = bvalid && bready;
    assign w_r_hs       = rvalid && rready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_we      <= 1'b0;
            ack       <= '0;
            wr_go     <= 1'b0;
            rd_go     <= 1'b0;
            busy      <= 1'b0;
            waddr     <= '0;
            raddr     <= '0;
            w_data    <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
            grant_idx <= '0;
        end else begin
            // Pulses default low; each state raises only what it owns.
            wr_go <= 1'b0;
            rd_go <= 1'b0;
            ack   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        grant_idx <= w_pick_idx;
                        r_we      <= req_we[w_pick_idx];
                        if (req_we[w_pick_idx]) begin
                            waddr  <= w_pick_addr;
                            w_data <= w_pick_wdata;
                            wr_go  <= 1'b1;
                        end else begin
                            raddr  <= w_pick_addr;
                            rd_go  <= 1'b1;
                        end
                        busy    <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The go pulse is visible during this state; the master
                    // has accepted it by the time we start snooping.
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Only the handshake of the granted direction completes.
                    if (r_we && w_b_hs) begin
                        rsp_resp  <= bresp;
                        rsp_rdata <= '0;
                        ack       <= NREQ'(1) << grant_idx;
                        r_state   <= S_DONE;
                    end else if (!r_we && w_r_hs) begin
                        rsp_resp  <= rresp;
                        rsp_rdata <= rdata;
                        ack       <= NREQ'(1) << grant_idx;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ptr   <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// tb/tb_axi_lite_rr_arbiter.sv - scoreboard bench for axi_lite_rr_arbiter
module tb_axi_lite_rr_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int IW   = 2;

    logic              aclk = 1'b0;
    logic              areset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   ack;
    logic [DW-1:0]     rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              busy;
    logic [IW-1:0]     grant_idx;
    logic              wr_go, rd_go;
    logic [AW-1:0]     waddr, raddr;
    logic [DW-1:0]     w_data;
    logic              bvalid, bready, rvalid, rready;
    logic [1:0]        bresp, rresp;
    logic [DW-1:0]     rdata;

    always #5 aclk = ~aclk;

    axi_lite_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .aclk(aclk), .areset(areset),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .busy(busy), .grant_idx(grant_idx),
        .wr_go(wr_go), .rd_go(rd_go), .waddr(waddr), .raddr(raddr), .w_data(w_data),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [1:0]    resp;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   grants[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: rr pointer and a one-outstanding slave.
    int   ptr_m = 0;
    bit   pend_active = 0;
    bit   pend_we;
    int   pend_idx;
    int   pend_delay;
    int   wr_cnt = 0, rd_cnt = 0, ack_count = 0;

    // Knobs set by the directed sequence.
    bit            rand_slave = 0;
    bit            spurious = 0;
    bit            auto_all = 0;
    bit            auto_rand = 0;
    int            fix_delay = 3;
    logic [1:0]    fix_resp = 2'b00;
    logic [DW-1:0] fix_rdata = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(logic [NREQ-1:0] r, int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Environment: slave model, requester behaviour, command-side checks.
    initial begin
        exp_t x;
        int e;
        logic [1:0] rs;
        logic [DW-1:0] rd;
        bvalid = 0; bready = 0; rvalid = 0; rready = 0;
        bresp = 0; rresp = 0; rdata = 0;
        forever begin
            @(negedge aclk);
            bvalid = 0; bready = 0; rvalid = 0; rready = 0;
            if (areset) begin
                pend_active = 0;
                ptr_m = 0;
                exp_q.delete();
            end else begin
                if (wr_go) wr_cnt++;
                if (rd_go) rd_cnt++;
                if (wr_go || rd_go) begin
                    e = pick(req, ptr_m);
                    chk("go_has_req", e >= 0, 1);
                    if (e < 0) e = 0;
                    chk("go_exclusive", wr_go && rd_go, 0);
                    chk("grant_idx", grant_idx, e);
                    chk("go_dir", wr_go, req_we[e]);
                    chk("busy_at_go", busy, 1);
                    if (req_we[e]) begin
                        chk("waddr", waddr, req_addr[e*AW +: AW]);
                        chk("w_data", w_data, req_wdata[e*DW +: DW]);
                    end else begin
                        chk("raddr", raddr, req_addr[e*AW +: AW]);
                    end
                    grants.push_back(e);
                    pend_active = 1;
                    pend_idx = e;
                    pend_we = req_we[e];
                    pend_delay = rand_slave ? int'($urandom_range(1, 5)) : fix_delay;
                end else if (pend_active) begin
                    pend_delay--;
                    if (pend_delay <= 0) begin
                        rs = rand_slave ? 2'($urandom) : fix_resp;
                        rd = rand_slave ? $urandom : fix_rdata;
                        x.idx = IW'(pend_idx);
                        x.resp = rs;
                        if (pend_we) begin
                            bvalid = 1; bready = 1; bresp = rs; rdata = $urandom;
                            x.rdata = '0;
                            chk("waddr_hold", waddr, req_addr[pend_idx*AW +: AW]);
                        end else begin
                            rvalid = 1; rready = 1; rresp = rs; rdata = rd;
                            x.rdata = rd;
                            chk("raddr_hold", raddr, req_addr[pend_idx*AW +: AW]);
                        end
                        exp_q.push_back(x);
                        pend_active = 0;
                    end else if (spurious || (rand_slave && $urandom_range(0, 2) == 0)) begin
                        // Other-direction handshake plus own valid without ready.
                        if (pend_we) begin
                            rvalid = 1; rready = 1; rresp = 2'b11; rdata = $urandom;
                            bvalid = 1; bready = 0; bresp = 2'b11;
                        end else begin
                            bvalid = 1; bready = 1; bresp = 2'b11;
                            rvalid = 1; rready = 0; rdata = $urandom;
                        end
                    end
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (ack[i]) begin
                        req[i] = 0;
                        ptr_m = (i + 1) % NREQ;
                        ack_count++;
                    end else if (!req[i] && (auto_all || (auto_rand && $urandom_range(0, 3) == 0))) begin
                        req_we[i] = 1'($urandom);
                        req_addr[i*AW +: AW] = $urandom;
                        req_wdata[i*DW +: DW] = $urandom;
                        req[i] = 1;
                    end
                end
            end
        end
    end

    // Monitor: every ack must match the next scoreboard entry.
    initial begin
        exp_t x;
        forever begin
            @(negedge aclk);
            if (!areset && ack != 0) begin
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", ack, 0);
                end else begin
                    x = exp_q.pop_front();
                    chk("ack_onehot", ack, NREQ'(1) << x.idx);
                    chk("rsp_rdata", rsp_rdata, x.rdata);
                    chk("rsp_resp", rsp_resp, x.resp);
                    chk("busy_at_ack", busy, 1);
                end
            end
        end
    end

    task automatic issue(int i, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req[i] = 1;
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while ((req != 0 || busy) && n < budget);
        chk("idle_timeout", (req != 0 || busy), 0);
        @(posedge aclk); #1;
    endtask

    initial begin
        int base;
        int n;
        int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
        areset = 1;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge aclk);
        #1 areset = 0;
        @(negedge aclk);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_go", {wr_go, rd_go}, 0);
        chk("rst_rsp", {rsp_resp, rsp_rdata}, 0);
        chk("rst_addr", {waddr, raddr, w_data}, 0);
        @(posedge aclk); #1;

        // Single write
        wr_cnt = 0; rd_cnt = 0;
        fix_delay = 3; fix_resp = 2'b00;
        issue(1, 1, 32'h10, 32'hDEADBEEF);
        wait_idle(50);
        chk("t1_wr_pulses", wr_cnt, 1);
        chk("t1_rd_pulses", rd_cnt, 0);

        // Single read
        wr_cnt = 0; rd_cnt = 0;
        fix_rdata = 32'hA5A5_0001;
        issue(2, 0, 32'h20, 32'h0);
        wait_idle(50);
        chk("t2_rd_pulses", rd_cnt, 1);
        chk("t2_wr_pulses", wr_cnt, 0);

        // Error write with spurious R handshakes, then a normal read
        spurious = 1; fix_delay = 5; fix_resp = 2'b10;
        issue(0, 1, 32'h40, 32'h1234_5678);
        wait_idle(50);
        spurious = 0; fix_delay = 2; fix_resp = 2'b00; fix_rdata = 32'h0BAD_F00D;
        issue(3, 0, 32'h44, 32'h0);
        wait_idle(50);
        chk("t3_grant_after_err", grants[grants.size()-1], 3);

        // Reset during WAIT
        fix_delay = 50;
        base = grants.size();
        issue(2, 0, 32'h30, 32'h0);
        n = 0;
        while (grants.size() == base && n < 20) begin @(negedge aclk); n++; end
        chk("t5_granted", grants.size(), base + 1);
        repeat (3) @(posedge aclk);
        #1 areset = 1; req = '0;
        @(posedge aclk); #1 areset = 0;
        @(negedge aclk);
        chk("t5_busy", busy, 0);
        chk("t5_ack", ack, 0);
        chk("t5_grant_idx", grant_idx, 0);
        @(posedge aclk); #1;
        fix_delay = 2;
        issue(3, 1, 32'h50, 32'h5555_AAAA);
        issue(1, 0, 32'h54, 32'h0);
        wait_idle(80);
        chk("t5_first_after_rst", grants[grants.size()-2], 1);
        chk("t5_second_after_rst", grants[grants.size()-1], 3);

        // Round-robin with all requesters continuously requesting
        rand_slave = 1;
        base = grants.size();
        n = ack_count;
        auto_all = 1;
        for (int i = 0; i < NREQ; i++) issue(i, 1'($urandom), $urandom, $urandom);
        begin
            int c = 0;
            while (ack_count < n + 6 && c < 200) begin @(negedge aclk); c++; end
        end
        @(posedge aclk); #1 auto_all = 0;
        wait_idle(200);
        for (int k = 0; k < 6; k++)
            chk($sformatf("rr_order_%0d", k), (base + k < grants.size()) ? grants[base + k] : -1, rr_exp[k]);

        // Random traffic
        auto_rand = 1;
        repeat (400) @(posedge aclk);
        #1 auto_rand = 0;
        wait_idle(400);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_rr_arbiter.md
Name: axi_lite_rr_arbiter

Overview:
- Shares one axi_lite_master command interface (wr_go/rd_go, waddr/raddr/w_data) between NREQ requesters.
- Arbitration is round-robin, with exactly one AXI-lite transaction outstanding at a time.
- Completion is detected by snooping the master's B and R channel handshakes. The response is returned to the granted requester as a one-cycle ack carrying read data and resp.
- Sits between internal register-access clients and axi_lite_master.

Parameters:
NREQ, 4, number of requesters (2..8); index 0 has highest priority after reset.
AW, 32, address width.
DW, 32, data width.

Ports:
aclk  in  1  clock, rising edge.
areset  in  1  reset, synchronous, active-high.
req  in  NREQ  request per requester; held high until ack.
req_we  in  NREQ  1 = write, 0 = read; qualified by req.
req_addr  in  NREQ*AW  packed; requester i at bits [i*AW +: AW].
req_wdata  in  NREQ*DW  packed write data, same packing.
ack  out  NREQ  one-hot, one-cycle completion pulse to the granted requester.
rsp_rdata  out  DW  read data; valid only in the ack cycle of a read.
rsp_resp  out  2  bresp/rresp of the completed transaction; valid in the ack cycle.
busy  out  1  high from grant until ack (inclusive).
grant_idx  out  $clog2(NREQ)  index of the current or last grant.
wr_go  out  1  write start pulse to the master.
rd_go  out  1  read start pulse to the master.
waddr  out  AW  write address to the master.
raddr  out  AW  read address to the master.
w_data  out  DW  write data to the master.
bvalid, bready  in  1 each  snooped B handshake.
bresp  in  2  snooped write response.
rvalid, rready  in  1 each  snooped R handshake.
rdata  in  DW  snooped read data.
rresp  in  2  snooped read response.

Behaviour:
- All outputs are registered.
- On areset at a rising edge, from any state:
  - state = IDLE, rr pointer = 0.
  - ack, wr_go, rd_go, busy = 0.
  - waddr, raddr, w_data, rsp_rdata, rsp_resp, grant_idx = 0.
  - Any in-flight transaction is abandoned; nothing is acked.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward from the rr pointer, wrapping at NREQ.
  - Latch grant_idx, the direction (req_we), the address and the write data.
  - Drive waddr/w_data for a write or raddr for a read; set busy=1; go to ISSUE.
  - With no req bit set, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - wr_go=1 for a write or rd_go=1 for a read, never both.
  - Addresses and data are held stable through the end of WAIT. Go to WAIT.
- WAIT:
  - Write: complete on the first cycle with bvalid&&bready; capture bresp.
  - Read: complete on rvalid&&rready; capture rdata and rresp.
  - The handshake of the other direction is ignored.
  - No timeout: WAIT persists indefinitely.
  - On completion go to DONE.
- DONE (1 cycle):
  - ack[grant_idx]=1; rsp_rdata and rsp_resp are valid.
  - For a write, rsp_rdata = 0.
  - rr pointer = (grant_idx+1) mod NREQ; busy=1. Next state is IDLE.
- Cycle after DONE: ack=0, busy=0, IDLE.
  - rsp_* hold their values until the next DONE.
- Requester obligations:
  - req, req_we, addr and data must stay stable until ack.
  - A requester must deassert req in the cycle after ack. If req is still high in IDLE, it is treated as a new request.
- Minimum turnaround: back-to-back grants are separated by at least one IDLE cycle.
- Latency: req sampled in IDLE at edge N.
  - Go pulse is high in cycle N+1.
  - Ack arrives one cycle after the edge that samples the B/R handshake.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 transactions.
- Requests arriving during ISSUE/WAIT/DONE are not lost. They are evaluated in the next IDLE.

Test Plan:
- Single write: req[1]=1, we=1, addr=0x10, wdata=0xDEADBEEF; slave returns bresp=00 three cycles after wr_go -> wr_go is a single pulse with waddr=0x10 and w_data=0xDEADBEEF; ack=4'b0010 for one cycle; rsp_resp=00; rd_go never asserts.
- Single read: req[2]=1, we=0, addr=0x20; slave returns rdata=0xA5A5_0001, rresp=00 -> rd_go pulses once; ack=4'b0100 with rsp_rdata=0xA5A5_0001; rsp_resp=00.
- Round-robin: all four req high, each re-asserted after its ack -> grant order 0,1,2,3,0,1; no duplicate grant while another requester is pending.
- Error response: write answered with bresp=2'b10 -> rsp_resp=2'b10 in the ack cycle; the next requester is then granted normally.
- Reset mid-operation: areset asserted for one cycle during WAIT -> next cycle state is IDLE, busy=0, ack=0, grant_idx=0; a later req[3] is served with pointer-0 priority.
- Spurious handshake: rvalid&&rready pulse while a write is in WAIT -> ignored, no ack until bvalid&&bready.
